// File: rtl/cam_table.sv
// cam_table: writable {len, key} content-addressable table with a registered priority-encoded search.
// Latency: search result 1 cycle after srch_en (rsp_valid pulse); full/free_addr are combinational.
// Backpressure: none; searches, writes and invalidates are accepted every cycle.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset (clears valid bits and response regs)
//   wr_en/wr_addr/wr_key/wr_len   store {wr_len, wr_key} at wr_addr and mark it valid
//   inv_en/inv_addr         clear the valid bit of inv_addr
//   clr_all                 clear every valid bit
//   srch_en/srch_key/srch_len     search request, compared at full {len, key} width
//   rsp_valid/hit/hit_addr/multi_hit   registered search response (held between searches)
//   full/free_addr/valid_vec      table occupancy, post-edge state
// Optional: define CAM_STATS_EN to add saturating hit_cnt/miss_cnt response counters.

module cam_table #(
  parameter int KEY_W  = 64,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic              clr_all,
  input  logic              srch_en,
  input  logic [KEY_W-1:0]  srch_key,
  input  logic [LEN_W-1:0]  srch_len,
  output logic              rsp_valid,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_addr,
  output logic              multi_hit,
  output logic              full,
  output logic [ADDR_W-1:0] free_addr,
  output logic [DEPTH-1:0]  valid_vec
`ifdef CAM_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int ENT_W = LEN_W + KEY_W;

  // Entry storage. Only the valid bits are reset; stale key/len contents
  // are harmless because matching is qualified by valid.
  logic [ENT_W-1:0] ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  logic             wr_ok;
  logic             inv_ok;
  logic [DEPTH-1:0] match_vec;
  logic             any_match;
  logic             many_match;
  logic [ADDR_W-1:0] match_idx;

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two;
  // such accesses are dropped entirely.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  // Lowest set bit index of v, 0 when v is all zero.
  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [DEPTH-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ADDR_W'(i);
      end
    end
    return idx;
  endfunction

  assign wr_ok  = wr_en  && addr_in_range(wr_addr);
  assign inv_ok = inv_en && addr_in_range(inv_addr);

  // ---------------------------------------------------------------------
  // Valid-bit update. Ordering gives the required precedence:
  // clr_all, then invalidate, then write (write always wins).
  // ---------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end
    if (inv_ok) begin
      valid_d[inv_addr] = 1'b0;
    end
    if (wr_ok) begin
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Key/len storage: no reset, but a write during reset is still suppressed
  // so reset fully overrides the write port.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      ent_q[wr_addr] <= {wr_len, wr_key};
    end
  end

  // ---------------------------------------------------------------------
  // Search: compares against pre-edge contents, so a same-cycle write or
  // invalidate is not visible to the search.
  // ---------------------------------------------------------------------
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (ent_q[i] == {srch_len, srch_key});
    end
  end

  assign any_match  = |match_vec;
  // Clearing the lowest set bit leaves something only if two or more matched.
  assign many_match = |(match_vec & (match_vec - DEPTH'(1)));
  assign match_idx  = lowest_idx(match_vec);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      hit       <= 1'b0;
      hit_addr  <= '0;
      multi_hit <= 1'b0;
    end else begin
      rsp_valid <= srch_en;
      if (srch_en) begin
        hit       <= any_match;
        hit_addr  <= match_idx;
        multi_hit <= many_match;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Occupancy status, from the registered valid bits.
  // ---------------------------------------------------------------------
  assign valid_vec = valid_q;
  assign full      = &valid_q;
  assign free_addr = lowest_idx(~valid_q);

`ifdef CAM_STATS_EN
  // Counters step on the same edge that raises rsp_valid. clr_all clears
  // them and takes precedence over a search counted in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_all) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (srch_en) begin
      if (any_match) begin
        if (hit_cnt != 16'hFFFF) begin
          hit_cnt <= hit_cnt + 16'd1;
        end
      end else begin
        if (miss_cnt != 16'hFFFF) begin
          miss_cnt <= miss_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule
